// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller: FSM state
// encoding, forwarding-select codes and the register-match helper.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } hazState_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Register 0 is hard-wired to zero, so it never creates a dependency.
    function automatic logic regMatch(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// Combinational EX-operand forwarding select for one source register.
// The younger producer in EX/MEM takes precedence over MEM/WB.
module hazard_fwd_unit
    import hazard_pkg::*;
(
    input  logic [4:0] i_exSrc,
    input  logic [4:0] i_memRd,
    input  logic       i_memRegWrite,
    input  logic [4:0] i_wbRd,
    input  logic       i_wbRegWrite,
    output logic [1:0] o_fwdSel
);

    always_comb begin
        o_fwdSel = FWD_RF;
        if (i_memRegWrite && regMatch(i_memRd, i_exSrc)) begin
            o_fwdSel = FWD_MEM;
        end else if (i_wbRegWrite && regMatch(i_wbRd, i_exSrc)) begin
            o_fwdSel = FWD_WB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall scheduler for the 5-stage pipeline: freeze, flush, load-use bubble,
// forwarding select and dmem-wait timeout. Perf counters built only with HAZ_PERF_CNT_EN.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 8,
    parameter int PERF_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        ex_rs,
    input  logic [4:0]        ex_rt,
    input  logic [4:0]        ex_rd,
    input  logic              ex_mem_read,
    input  logic [4:0]        mem_rd,
    input  logic              mem_reg_write,
    input  logic [4:0]        wb_rd,
    input  logic              wb_reg_write,
    input  logic              branch_taken,
    input  logic              dmem_req,
    input  logic              dmem_ready,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              id_ex_en,
    output logic              ex_mem_en,
    output logic              mem_wb_en,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              dmem_timeout,
    output logic [PERF_W-1:0] stall_cnt,
    output logic [PERF_W-1:0] flush_cnt,
    output logic [PERF_W-1:0] wait_cnt
);

    hazState_t        r_state;
    hazState_t        w_nextState;
    logic [CNT_W-1:0] r_waitCnt;
    logic [CNT_W-1:0] w_waitNext;
    logic [4:0]       w_en;
    logic             w_freeze;
    logic             w_loadUse;
    logic             w_timeoutHit;
    logic [1:0]       w_fwdA;
    logic [1:0]       w_fwdB;

    assign w_freeze     = dmem_req && !dmem_ready;
    assign w_loadUse    = ex_mem_read && (regMatch(ex_rd, id_rs) || regMatch(ex_rd, id_rt));
    assign w_waitNext   = (r_state == RUN) ? CNT_W'(1) : r_waitCnt + CNT_W'(1);
    assign w_timeoutHit = (w_waitNext >= CNT_W'(MEM_TIMEOUT));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            RUN: begin
                if (w_freeze) begin
                    w_nextState = w_timeoutHit ? HALT : MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    w_nextState = RUN;
                end else if (w_timeoutHit) begin
                    w_nextState = HALT;
                end
            end
            HALT:    w_nextState = HALT;
            default: w_nextState = RUN;
        endcase
    end

    // Enable vector order: PC, IF/ID, ID/EX, EX/MEM, MEM/WB.
    always_comb begin
        w_en        = 5'b00000;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        if (reset) begin
            case (r_state)
                RUN: begin
                    if (!w_freeze) begin
                        w_en = 5'b11111;
                        if (branch_taken) begin
                            if_id_flush = 1'b1;
                            id_ex_flush = 1'b1;
                        end else if (w_loadUse) begin
                            w_en        = 5'b00111;
                            id_ex_flush = 1'b1;
                        end
                    end
                end
                MEM_WAIT: begin
                    if (dmem_ready) begin
                        w_en = 5'b11111;
                    end
                end
                default: w_en = 5'b00000;
            endcase
        end
    end

    assign {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = w_en;
    assign dmem_timeout = reset && (r_state == HALT);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_waitCnt <= '0;
        end else if (w_nextState == MEM_WAIT) begin
            r_waitCnt <= w_waitNext;
        end else begin
            r_waitCnt <= '0;
        end
    end

    hazard_fwd_unit u_fwdA (
        .i_exSrc       (ex_rs),
        .i_memRd       (mem_rd),
        .i_memRegWrite (mem_reg_write),
        .i_wbRd        (wb_rd),
        .i_wbRegWrite  (wb_reg_write),
        .o_fwdSel      (w_fwdA)
    );

    hazard_fwd_unit u_fwdB (
        .i_exSrc       (ex_rt),
        .i_memRd       (mem_rd),
        .i_memRegWrite (mem_reg_write),
        .i_wbRd        (wb_rd),
        .i_wbRegWrite  (wb_reg_write),
        .o_fwdSel      (w_fwdB)
    );

    assign fwd_a_sel = reset ? w_fwdA : FWD_RF;
    assign fwd_b_sel = reset ? w_fwdB : FWD_RF;

`ifdef HAZ_PERF_CNT_EN
    logic [PERF_W-1:0] r_stallCnt;
    logic [PERF_W-1:0] r_flushCnt;
    logic [PERF_W-1:0] r_waitPerf;
    logic              w_stallEv;
    logic              w_flushEv;
    logic              w_waitEv;

    assign w_stallEv = (r_state == RUN) && !w_freeze && !branch_taken && w_loadUse;
    assign w_flushEv = (r_state == RUN) && !w_freeze && branch_taken;
    assign w_waitEv  = ((r_state == RUN) && w_freeze) || ((r_state == MEM_WAIT) && !dmem_ready);

    // Counters saturate rather than wrap so long runs stay meaningful.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_stallCnt <= '0;
            r_flushCnt <= '0;
            r_waitPerf <= '0;
        end else begin
            if (w_stallEv && !(&r_stallCnt)) r_stallCnt <= r_stallCnt + 1'b1;
            if (w_flushEv && !(&r_flushCnt)) r_flushCnt <= r_flushCnt + 1'b1;
            if (w_waitEv  && !(&r_waitPerf)) r_waitPerf <= r_waitPerf + 1'b1;
        end
    end

    assign stall_cnt = r_stallCnt;
    assign flush_cnt = r_flushCnt;
    assign wait_cnt  = r_waitPerf;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
    assign wait_cnt  = '0;
`endif

endmodule
